// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status encoding, FSM states
// and the instruction-length decode used by the fetch stage.
package y86_pkg;

  localparam logic [3:0] IcodeHalt   = 4'h0;
  localparam logic [3:0] IcodeNop    = 4'h1;
  localparam logic [3:0] IcodeRrmovq = 4'h2;
  localparam logic [3:0] IcodeIrmovq = 4'h3;
  localparam logic [3:0] IcodeRmmovq = 4'h4;
  localparam logic [3:0] IcodeMrmovq = 4'h5;
  localparam logic [3:0] IcodeOpq    = 4'h6;
  localparam logic [3:0] IcodeJxx    = 4'h7;
  localparam logic [3:0] IcodeCall   = 4'h8;
  localparam logic [3:0] IcodeRet    = 4'h9;
  localparam logic [3:0] IcodePushq  = 4'hA;
  localparam logic [3:0] IcodePopq   = 4'hB;

  localparam logic [3:0] RegNone = 4'hF;

  typedef enum logic [1:0] {
    StatAok = 2'd0,
    StatHlt = 2'd1,
    StatAdr = 2'd2,
    StatIns = 2'd3
  } stat_e;

  typedef enum logic {
    StRun  = 1'b0,
    StHold = 1'b1
  } fetch_state_e;

  // Undefined icodes (C-F) decode as one byte so they can be reported as INS.
  function automatic logic [3:0] instr_len(input logic [3:0] code);
    case (code)
      IcodeRrmovq, IcodeOpq, IcodePushq, IcodePopq: instr_len = 4'd2;
      IcodeJxx, IcodeCall:                          instr_len = 4'd9;
      IcodeIrmovq, IcodeRmmovq, IcodeMrmovq:        instr_len = 4'd10;
      default:                                      instr_len = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/fetch_byte_queue.sv
// Circular byte queue between instruction memory and decode. Pushes FETCH_W
// bytes, pops 1..10 bytes, and exposes the ten bytes at the head.
module fetch_byte_queue #(
  parameter int unsigned FETCH_W = 4,
  parameter int unsigned QDEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      push,
  input  logic [FETCH_W*8-1:0]      push_data,
  input  logic [FETCH_W-1:0]        push_bad,
  input  logic                      pop,
  input  logic [3:0]                pop_len,
  output logic [$clog2(QDEPTH):0]   count,
  output logic [79:0]               peek_data,
  output logic [9:0]                peek_bad
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  logic [7:0]        data_q [QDEPTH];
  logic [QDEPTH-1:0] bad_q;
  logic [PW-1:0]     head_q;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     tail;

  assign tail  = head_q + count_q[PW-1:0];
  assign count = count_q;

  always_comb begin
    peek_data = '0;
    peek_bad  = '0;
    for (int i = 0; i < 10; i++) begin
      peek_data[i*8 +: 8] = data_q[head_q + PW'(i)];
      peek_bad[i]         = bad_q[head_q + PW'(i)];
    end
  end

  always_comb begin
    count_d = count_q;
    if (push) count_d = count_d + CW'(FETCH_W);
    if (pop)  count_d = count_d - CW'(pop_len);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop) head_q <= head_q + PW'(pop_len);
      count_q <= count_d;
    end
  end

  // Storage is not reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) begin
      for (int i = 0; i < FETCH_W; i++) begin
        data_q[tail + PW'(i)] <= push_data[i*8 +: 8];
        bad_q[tail + PW'(i)]  <= push_bad[i];
      end
    end
  end

endmodule

// File: rtl/pipe_fetch.sv
// Y86-64 fetch stage: streams instruction bytes into a queue, decodes the head
// instruction into a registered valid/ready output, and halts on faults/ret.
module pipe_fetch
  import y86_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 1024,
  parameter int unsigned FETCH_W    = 4,
  parameter int unsigned QDEPTH     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_BYTES)-1:0] imem_waddr,
  input  logic [7:0]                    imem_wdata,
  input  logic                          redirect_valid,
  input  logic [63:0]                   redirect_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [3:0]                    icode,
  output logic [3:0]                    ifun,
  output logic [3:0]                    rA,
  output logic [3:0]                    rB,
  output logic [63:0]                   valC,
  output logic [63:0]                   valP,
  output logic [63:0]                   pc,
  output logic [63:0]                   pred_pc,
  output logic [1:0]                    stat
);

  localparam int unsigned AW = $clog2(IMEM_BYTES);
  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  logic [7:0] imem [IMEM_BYTES];

  fetch_state_e state_q;
  logic [63:0]  fpc_q;
  logic [63:0]  dpc_q;

  logic [63:0]          fetch_addr [FETCH_W];
  logic [FETCH_W*8-1:0] fetch_data;
  logic [FETCH_W-1:0]   fetch_bad;
  logic [CW-1:0]        q_count, q_free;
  logic [79:0]          peek_data;
  logic [9:0]           peek_bad;
  logic                 push_en, load;

  logic [3:0]  icode_h, ifun_h, len_h, ra_h, rb_h;
  logic [63:0] valc_h, valp_h, pred_h;
  stat_e       stat_h;
  logic        avail, any_bad;

  always_ff @(posedge clk) begin
    if (rst_n && imem_we) imem[imem_waddr] <= imem_wdata;
  end

  always_comb begin
    fetch_data = '0;
    fetch_bad  = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      fetch_addr[i]       = fpc_q + 64'(i);
      fetch_bad[i]        = fetch_addr[i] >= 64'(IMEM_BYTES);
      fetch_data[i*8 +: 8] = fetch_bad[i] ? 8'h00 : imem[fetch_addr[i][AW-1:0]];
    end
  end

  assign q_free  = CW'(QDEPTH) - q_count;
  assign push_en = (state_q == StRun) && !redirect_valid && (q_free >= CW'(FETCH_W));

  fetch_byte_queue #(
    .FETCH_W (FETCH_W),
    .QDEPTH  (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push_en),
    .push_data (fetch_data),
    .push_bad  (fetch_bad),
    .pop       (load),
    .pop_len   (len_h),
    .count     (q_count),
    .peek_data (peek_data),
    .peek_bad  (peek_bad)
  );

  always_comb begin
    icode_h = peek_data[7:4];
    ifun_h  = peek_data[3:0];
    len_h   = instr_len(icode_h);
    avail   = q_count >= CW'(len_h);

    any_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if ((4'(i) < len_h) && peek_bad[i]) any_bad = 1'b1;
    end

    if (any_bad)                 stat_h = StatAdr;
    else if (icode_h >= 4'hC)    stat_h = StatIns;
    else if (icode_h == IcodeHalt) stat_h = StatHlt;
    else                         stat_h = StatAok;

    ra_h = RegNone;
    rb_h = RegNone;
    if (len_h == 4'd2 || len_h == 4'd10) begin
      ra_h = peek_data[15:12];
      rb_h = peek_data[11:8];
    end
    if (icode_h == IcodeIrmovq) ra_h = RegNone;
    if (icode_h == IcodePushq || icode_h == IcodePopq) rb_h = RegNone;

    case (icode_h)
      IcodeIrmovq, IcodeRmmovq, IcodeMrmovq: valc_h = peek_data[79:16];
      IcodeJxx, IcodeCall:                   valc_h = peek_data[71:8];
      default:                               valc_h = '0;
    endcase

    valp_h = dpc_q + 64'(len_h);
    pred_h = (icode_h == IcodeJxx || icode_h == IcodeCall) ? valc_h : valp_h;

    load = (state_q == StRun) && !redirect_valid && avail && (!out_valid || out_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StRun;
      fpc_q     <= '0;
      dpc_q     <= '0;
      out_valid <= 1'b0;
      icode     <= '0;
      ifun      <= '0;
      rA        <= RegNone;
      rB        <= RegNone;
      valC      <= '0;
      valP      <= '0;
      pc        <= '0;
      pred_pc   <= '0;
      stat      <= StatAok;
    end else if (redirect_valid) begin
      state_q   <= StRun;
      fpc_q     <= redirect_pc;
      dpc_q     <= redirect_pc;
      out_valid <= 1'b0;
    end else begin
      if (push_en) fpc_q <= fpc_q + 64'(FETCH_W);
      if (load) begin
        out_valid <= 1'b1;
        icode     <= icode_h;
        ifun      <= ifun_h;
        rA        <= ra_h;
        rB        <= rb_h;
        valC      <= valc_h;
        valP      <= valp_h;
        pc        <= dpc_q;
        pred_pc   <= pred_h;
        stat      <= stat_h;
        dpc_q     <= valp_h;
        // Faults and ret stop the stream until the back end redirects.
        if (stat_h != StatAok || icode_h == IcodeRet) state_q <= StHold;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_fetch.sv
// Directed bench for pipe_fetch (default parameters) with hand-computed
// expectations for decode fields, latency, stalls, faults and redirects.
module tb_pipe_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_we = 1'b0;
  logic [9:0]  imem_waddr = '0;
  logic [7:0]  imem_wdata = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP, pc, pred_pc;
  logic [1:0]  stat;

  int n_cmp = 0;
  int n_fail = 0;
  int n;
  int hits;

  pipe_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_we        (imem_we),
    .imem_waddr     (imem_waddr),
    .imem_wdata     (imem_wdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .icode          (icode),
    .ifun           (ifun),
    .rA             (rA),
    .rB             (rB),
    .valC           (valC),
    .valP           (valP),
    .pc             (pc),
    .pred_pc        (pred_pc),
    .stat           (stat)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bytes are little-endian in the vector: byte k is bytes[8k+7:8k].
  task automatic load_prog(input int unsigned addr, input logic [79:0] bytes, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      imem_we    = 1'b1;
      imem_waddr = 10'(addr + k);
      imem_wdata = bytes[k*8 +: 8];
      step();
    end
    imem_we = 1'b0;
  endtask

  task automatic redirect(input logic [63:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  // Returns the number of edges until out_valid; equals budget on timeout.
  task automatic wait_valid(input int budget, output int edges);
    edges = 0;
    do begin
      step();
      edges++;
    end while (!out_valid && edges < budget);
  endtask

  initial begin
    step();
    step();
    rst_n = 1'b1;
    step();

    // irmovq $6,%rax at 0 (byte 9 = halt), addq/nop/halt at 20
    load_prog(0, 80'h0000_0000_0000_0006_F030, 10);
    load_prog(20, 80'h0010_0360, 4);

    // Reset beats a same-cycle redirect and memory write; memory survives reset
    rst_n          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'd20;
    imem_we        = 1'b1;
    imem_waddr     = 10'd0;
    imem_wdata     = 8'hC0;
    step();
    step();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_icode", 64'(icode), 64'd0);
    check("rst_ifun", 64'(ifun), 64'd0);
    check("rst_rA", 64'(rA), 64'hF);
    check("rst_rB", 64'(rB), 64'hF);
    check("rst_valC", valC, 64'd0);
    check("rst_valP", valP, 64'd0);
    check("rst_pc", pc, 64'd0);
    check("rst_pred", pred_pc, 64'd0);
    check("rst_stat", 64'(stat), 64'd0);
    rst_n          = 1'b1;
    redirect_valid = 1'b0;
    imem_we        = 1'b0;

    // irmovq from pc 0: 10 bytes at 4 per cycle -> 4 edges
    wait_valid(20, n);
    check("irm_lat", 64'(n), 64'd4);
    check("irm_icode", 64'(icode), 64'h3);
    check("irm_ifun", 64'(ifun), 64'h0);
    check("irm_rA", 64'(rA), 64'hF);
    check("irm_rB", 64'(rB), 64'h0);
    check("irm_valC", valC, 64'd6);
    check("irm_valP", valP, 64'd10);
    check("irm_pc", pc, 64'd0);
    check("irm_pred", pred_pc, 64'd10);
    check("irm_stat", 64'(stat), 64'd0);

    // addq, nop, halt back to back from 20
    redirect(64'd20);
    wait_valid(20, n);
    check("add_lat", 64'(n), 64'd2);
    check("add_pc", pc, 64'd20);
    check("add_icode", 64'(icode), 64'h6);
    check("add_rA", 64'(rA), 64'h0);
    check("add_rB", 64'(rB), 64'h3);
    check("add_valP", valP, 64'd22);
    step();
    check("nop_valid", 64'(out_valid), 64'd1);
    check("nop_pc", pc, 64'd22);
    check("nop_icode", 64'(icode), 64'h1);
    step();
    check("hlt_valid", 64'(out_valid), 64'd1);
    check("hlt_pc", pc, 64'd23);
    check("hlt_stat", 64'(stat), 64'd1);
    check("hlt_valP", valP, 64'd24);
    hits = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (out_valid) hits++;
    end
    check("hlt_quiet", 64'(hits), 64'd0);

    // jmp 0x40 at 0 (byte 9 still halt), held under backpressure
    load_prog(0, 80'h40_70, 9);
    out_ready = 1'b0;
    redirect(64'd0);
    wait_valid(20, n);
    check("jmp_lat", 64'(n), 64'd4);
    check("jmp_icode", 64'(icode), 64'h7);
    check("jmp_valC", valC, 64'h40);
    check("jmp_valP", valP, 64'd9);
    check("jmp_pred", pred_pc, 64'h40);
    for (int c = 0; c < 5; c++) begin
      step();
      check("jmp_hold_valid", 64'(out_valid), 64'd1);
      check("jmp_hold_pc", pc, 64'd0);
      check("jmp_hold_pred", pred_pc, 64'h40);
    end
    out_ready = 1'b1;
    step();
    check("jmp_next_pc", pc, 64'd9);
    check("jmp_next_stat", 64'(stat), 64'd1);
    step();
    check("jmp_drained", 64'(out_valid), 64'd0);

    // irmovq straddling the top of memory
    load_prog(1020, 80'h0201_F230, 4);
    redirect(64'd1020);
    wait_valid(20, n);
    check("adr_lat", 64'(n), 64'd4);
    check("adr_stat", 64'(stat), 64'd2);
    check("adr_pc", pc, 64'd1020);
    check("adr_valP", valP, 64'd1030);
    hits = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (out_valid) hits++;
    end
    check("adr_hold", 64'(hits), 64'd0);

    // invalid opcode, then redirect while its output is still pending
    load_prog(5, 80'hC0, 1);
    out_ready = 1'b0;
    redirect(64'd5);
    wait_valid(20, n);
    check("ins_lat", 64'(n), 64'd2);
    check("ins_icode", 64'(icode), 64'hC);
    check("ins_stat", 64'(stat), 64'd3);
    check("ins_valP", valP, 64'd6);
    check("ins_pc", pc, 64'd5);
    check("ins_rB", 64'(rB), 64'hF);
    out_ready = 1'b1;
    redirect(64'd20);
    check("rdr_drop", 64'(out_valid), 64'd0);
    wait_valid(20, n);
    check("rdr_lat", 64'(n), 64'd2);
    check("rdr_pc", pc, 64'd20);
    check("rdr_icode", 64'(icode), 64'h6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_fetch.md
PIPE_FETCH -- requirements
Module: pipe_fetch

Interface
REQ-001 SHALL have parameter IMEM_BYTES, default 1024, instruction memory size in bytes.
REQ-002 SHALL have parameter FETCH_W, default 4, bytes read from memory per cycle (1..8).
REQ-003 SHALL have parameter QDEPTH, default 16, byte-queue capacity; power of two, at least FETCH_W+10.
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset; synchronous and active-low.
REQ-006 SHALL have ports imem_we  in  1, imem_waddr  in  log2(IMEM_BYTES), imem_wdata  in  8: program-load byte write.
REQ-007 SHALL have ports redirect_valid  in  1, redirect_pc  in  64: flush and restart fetch at redirect_pc.
REQ-008 SHALL have ports out_valid  out  1, out_ready  in  1: decoded-instruction handshake.
REQ-009 SHALL have outputs icode 4, ifun 4, rA 4, rB 4, valC 64, valP 64, pc 64, pred_pc 64, stat 2.

Function
REQ-010 SHALL hold a byte queue (head, count) filled from fetch address fpc; each edge with free space >= FETCH_W and state RUN appends bytes fpc..fpc+FETCH_W-1 and advances fpc by FETCH_W.
REQ-011 SHALL tag each queued byte bad if its address >= IMEM_BYTES; bad bytes read as 0x00.
REQ-012 SHALL decode length from head icode: 0,1,9 -> 1; 2,6,A,B -> 2; 7,8 -> 9; 3,4,5 -> 10; C-F -> 1.
REQ-013 SHALL load the output register when the head instruction is fully queued and (out_valid==0 or out_ready==1), then pop that many bytes in the same edge.
REQ-014 SHALL hold all outputs stable while out_valid==1 and out_ready==0.
REQ-015 SHALL set rA/rB from byte 1 (high/low nibble) for lengths 2 and 10 (rA=0xF for irmovq), else 0xF; push/pop rB SHALL be forced to 0xF.
REQ-016 SHALL assemble valC little-endian: bytes 2-9 for icode 3,4,5; bytes 1-8 for icode 7,8; else 0.
REQ-017 SHALL output pc = instruction address, valP = pc + length (64-bit wrap).
REQ-018 SHALL output pred_pc = valC for icode 7 and 8, else valP.
REQ-019 SHALL encode stat AOK=0, HLT=1, ADR=2, INS=3; ADR takes precedence when any byte of the instruction is bad, then INS for icode C-F, then HLT for icode 0.
REQ-020 SHALL use states RUN and HOLD: RUN -> HOLD on emitting stat != AOK or icode 9 (ret); HOLD stops fetch and decode; HOLD -> RUN only on redirect.
REQ-021 SHALL, on redirect_valid, flush queue, set fpc = pc-tracker = redirect_pc, clear out_valid, enter RUN; redirect overrides a simultaneous output load or handshake.
REQ-022 SHALL fetch aligned to redirect_pc (no alignment to FETCH_W).
REQ-023 SHALL apply imem writes at the edge; bytes already queued are not updated.
REQ-024 SHALL give latency: redirect sampled at edge E0, an instruction of length L emits at edge E(ceil(L/FETCH_W)+1) when out_ready is held 1.

Reset
REQ-025 SHALL on rst_n==0 clear queue, set fpc=0, state RUN, out_valid=0, icode=ifun=0, rA=rB=0xF, valC=valP=pc=pred_pc=0, stat=AOK; memory contents are not cleared.
REQ-026 SHALL let reset override redirect and imem writes in the same cycle.

Structure
REQ-027 SHALL place icode constants, stat encoding and the length function in shared package y86_pkg.
REQ-028 SHALL implement the byte queue as sub-module fetch_byte_queue (push FETCH_W, pop 1..10, count output).

Verification
REQ-029 SHALL cover: load irmovq $6,%rax at 0 (30 F0 06 00..00), redirect 0, FETCH_W=4 -> out_valid at E4, rB=0, valC=6, valP=10, stat=AOK.
REQ-030 SHALL cover: addq 60 03, nop, halt at 20 -> three outputs pc 20/22/23, last stat=HLT, no further out_valid for 20 cycles.
REQ-031 SHALL cover: jmp 0x40 at 0, out_ready=0 for 5 cycles -> outputs stable, pred_pc=0x40, then one handshake only.
REQ-032 SHALL cover: redirect 1020 with 10-byte irmovq -> stat=ADR, state HOLD.
REQ-033 SHALL cover: byte 0xC0 at 5 -> stat=INS, valP=6; redirect asserted same cycle as a pending output -> output dropped, next output from redirect_pc.
